// File: rtl/seg_scan_capture_if.sv
// Bundle between the scanned 7-segment pins and the frame decoded from them.
// The bus has no backpressure. The display side owns select_light/display_char.
// The capture side raises frame_valid for exactly one cycle when a frame is ready.
// digits_bcd/dp_mask/err_mask are stable whenever frame_valid is high, and they hold until the next frame.
interface seg_scan_capture_if #(
  parameter int DIGITS = 8
);
  logic [DIGITS-1:0]   select_light;
  logic [7:0]          display_char;
  logic [4*DIGITS-1:0] digits_bcd;
  logic [DIGITS-1:0]   dp_mask;
  logic [DIGITS-1:0]   err_mask;
  logic                frame_valid;
  logic                scan_lost;
  logic [1:0]          fsm_state;

  modport master (
    output select_light, display_char,
    input  digits_bcd, dp_mask, err_mask, frame_valid, scan_lost, fsm_state
  );

  modport slave (
    input  select_light, display_char,
    output digits_bcd, dp_mask, err_mask, frame_valid, scan_lost, fsm_state
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed 7-segment scan, decodes each settled digit to a nibble,
// and publishes a full frame once every digit position has been captured.
module seg_scan_capture #(
  parameter int DIGITS  = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic              CP,
  input  logic              CR,
  seg_scan_capture_if.slave bus
);
  localparam int SW  = $clog2(SETTLE);
  localparam int IW  = $clog2(TIMEOUT + 1);
  localparam int IXW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLING = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DIGITS-1:0]   sel_q, sel_p, seen;
  logic [7:0]          seg_q, seg_p;
  logic [SW-1:0]       stab_cnt;
  logic [IW-1:0]       idle_cnt;
  logic [4*DIGITS-1:0] shadow_bcd, mrg_bcd, digits_r;
  logic [DIGITS-1:0]   shadow_dp, shadow_err, mrg_dp, mrg_err, dp_r, err_r;
  logic                frame_r, lost_r;
  logic                one_hot, stable, capture;
  logic [IXW-1:0]      slot;
  logic [3:0]          dec_nib;
  logic                dec_err;

  assign one_hot = (sel_q != '0) && ((sel_q & (sel_q - DIGITS'(1))) == '0);
  assign stable  = one_hot && (sel_q == sel_p) && (seg_q == seg_p);

  always_ff @(posedge CP) begin
    if (CR) state <= S_IDLE;
    else    state <= state_nxt;
  end

  // Any change restarts settling; a settled dwell sits in HELD until the pins move.
  always_comb begin
    state_nxt = state;
    if (!one_hot)     state_nxt = S_IDLE;
    else if (!stable) state_nxt = S_SETTLING;
    else if (capture) state_nxt = S_HELD;
  end

  always_comb begin
    capture       = (state == S_SETTLING) && stable && (stab_cnt == SW'(SETTLE - 2));
    bus.fsm_state = state;
  end

  always_comb begin
    slot = '0;
    for (int i = 0; i < DIGITS; i++)
      if (sel_q[i]) slot = IXW'(i);
  end

  always_comb begin
    dec_err = 1'b0;
    case (seg_q[6:0])
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h40: dec_nib = 4'hA;
      7'h00: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'hE;
        dec_err = 1'b1;
      end
    endcase
  end

  // Shadow frame with the digit being captured this cycle already merged in.
  always_comb begin
    mrg_bcd                  = shadow_bcd;
    mrg_dp                   = shadow_dp;
    mrg_err                  = shadow_err;
    mrg_bcd[{slot, 2'b00} +: 4] = dec_nib;
    mrg_dp[slot]             = seg_q[7];
    mrg_err[slot]            = dec_err;
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      sel_q      <= '0;
      sel_p      <= '0;
      seg_q      <= '0;
      seg_p      <= '0;
      stab_cnt   <= '0;
      idle_cnt   <= '0;
      seen       <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      shadow_err <= '0;
      digits_r   <= '0;
      dp_r       <= '0;
      err_r      <= '0;
      frame_r    <= 1'b0;
      lost_r     <= 1'b0;
    end else begin
      sel_q   <= bus.select_light;
      seg_q   <= bus.display_char;
      sel_p   <= sel_q;
      seg_p   <= seg_q;
      frame_r <= 1'b0;

      if (!stable)                          stab_cnt <= '0;
      else if (stab_cnt != SW'(SETTLE - 1)) stab_cnt <= stab_cnt + SW'(1);

      if (capture) begin
        shadow_bcd <= mrg_bcd;
        shadow_dp  <= mrg_dp;
        shadow_err <= mrg_err;
        idle_cnt   <= '0;
        lost_r     <= 1'b0;
        if (&(seen | sel_q)) begin
          digits_r <= mrg_bcd;
          dp_r     <= mrg_dp;
          err_r    <= mrg_err;
          frame_r  <= 1'b1;
          seen     <= '0;
        end else begin
          seen <= seen | sel_q;
        end
      end else if (idle_cnt == IW'(TIMEOUT)) begin
        lost_r <= 1'b1;
        seen   <= '0;
      end else begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  assign bus.digits_bcd  = digits_r;
  assign bus.dp_mask     = dp_r;
  assign bus.err_mask    = err_r;
  assign bus.frame_valid = frame_r;
  assign bus.scan_lost   = lost_r;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: dwell-level reference model feeding an expected-frame queue,
// with a separate monitor that checks every frame_valid pulse against it.
module tb_seg_scan_capture;
  localparam int DIGITS  = 8;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_capture_if #(.DIGITS(DIGITS)) bus();

  seg_scan_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .CP (clk),
    .CR (rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [47:0] exp_q[$];
  logic [31:0] last_bcd;
  logic [7:0]  last_dp, last_err;

  logic [7:0] seg_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Reference model state: dwell runs on the pins and the frame being assembled.
  logic [31:0] m_bcd;
  logic [7:0]  m_dp, m_err, m_seen;
  logic [7:0]  cur_sel, cur_seg;
  int          run_start, run_len, cyc, last_cap;
  bit          run_cap;

  function automatic logic [4:0] decode(input logic [6:0] s);
    for (int d = 0; d < 10; d++)
      if (seg_tab[d][6:0] == s) return {1'b0, 4'(d)};
    if (s == 7'h40) return 5'h0A;
    if (s == 7'h00) return 5'h0F;
    return 5'h1E;
  endfunction

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_step(input logic [7:0] sel, input logic [7:0] seg, input int n);
    int cap_edge, d;
    logic [4:0] dec;
    if (sel !== cur_sel || seg !== cur_seg) begin
      cur_sel = sel; cur_seg = seg;
      run_start = cyc; run_len = 0; run_cap = 0;
    end
    run_len += n;
    if ($countones(sel) == 1 && !run_cap && run_len >= SETTLE) begin
      cap_edge = run_start + SETTLE;
      if (cap_edge - last_cap > TIMEOUT + 1) m_seen = '0;
      last_cap = cap_edge;
      run_cap  = 1;
      d   = idx_of(sel);
      dec = decode(seg[6:0]);
      m_bcd[4*d +: 4] = dec[3:0];
      m_dp[d]   = seg[7];
      m_err[d]  = dec[4];
      m_seen[d] = 1'b1;
      if (&m_seen) begin
        exp_q.push_back({m_bcd, m_dp, m_err});
        m_seen = '0;
      end
    end
    cyc += n;
  endtask

  task automatic dwell(input logic [7:0] sel, input logic [7:0] seg, input int n);
    model_step(sel, seg, n);
    bus.select_light = sel;
    bus.display_char = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int d, input logic [7:0] seg, input int n);
    logic [7:0] s;
    s = 8'(1 << d);
    dwell(s, seg, n);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.select_light = 8'($urandom);
    bus.display_char = 8'($urandom);
    repeat (2) @(negedge clk);
    check({tag, "_digits"}, 48'(bus.digits_bcd), 48'h0);
    check({tag, "_dp"},     48'(bus.dp_mask), 48'h0);
    check({tag, "_err"},    48'(bus.err_mask), 48'h0);
    check({tag, "_valid"},  48'(bus.frame_valid), 48'h0);
    check({tag, "_lost"},   48'(bus.scan_lost), 48'h0);
    bus.select_light = '0;
    bus.display_char = '0;
    rst = 1'b0;
    m_seen = '0; cur_sel = '0; cur_seg = '0;
    run_cap = 0; run_len = 0; run_start = cyc; last_cap = cyc;
  endtask

  always @(negedge clk) begin
    if (bus.frame_valid) begin
      frames++;
      last_bcd = bus.digits_bcd;
      last_dp  = bus.dp_mask;
      last_err = bus.err_mask;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame actual=%0h required=none", bus.digits_bcd);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check("frame_digits", 48'(bus.digits_bcd), 48'(e[47:16]));
        check("frame_dp",     48'(bus.dp_mask),    48'(e[15:8]));
        check("frame_err",    48'(bus.err_mask),   48'(e[7:0]));
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, p, sel_kind;
    logic [7:0] seg, junk;
    m_bcd = '0; m_dp = '0; m_err = '0; m_seen = '0;
    cur_sel = '0; cur_seg = '0; cyc = 0; last_cap = 0; run_start = 0; run_len = 0; run_cap = 0;
    bus.select_light = '0;
    bus.display_char = '0;
    @(negedge clk);
    do_reset("reset");

    // "12345678" with decimal point on digit 2
    f0 = frames;
    for (int d = 0; d < 8; d++) digit(d, seg_tab[d + 1] | ((d == 2) ? 8'h80 : 8'h00), 8);
    dwell(8'h00, 8'h00, 4);
    check("scan_frames", 48'(frames - f0), 48'd1);
    check("scan_digits", 48'(last_bcd), 48'h87654321);
    check("scan_dp",     48'(last_dp), 48'h04);
    check("scan_err",    48'(last_err), 48'h00);

    // Dwell one short of SETTLE must not capture; a full SETTLE dwell must
    f0 = frames;
    for (int d = 0; d < 7; d++) digit(d, seg_tab[d], 8);
    digit(7, seg_tab[7], SETTLE - 1);
    dwell(8'h00, 8'h00, 6);
    check("short_dwell_frames", 48'(frames - f0), 48'd0);
    digit(7, seg_tab[7], SETTLE);
    dwell(8'h00, 8'h00, 4);
    check("settle_dwell_frames", 48'(frames - f0), 48'd1);
    check("settle_digits", 48'(last_bcd), 48'h76543210);

    // Non-one-hot selects between digits are ignored
    f0 = frames;
    for (int d = 0; d < 8; d++) begin
      digit(d, seg_tab[9 - d], 6);
      dwell((d % 2 == 0) ? 8'h03 : 8'h00, 8'(d), 3);
    end
    check("junk_sel_frames", 48'(frames - f0), 48'd1);
    check("junk_sel_digits", 48'(last_bcd), 48'h23456789);

    // Undecodable pattern on digit 5, blank on digit 7
    for (int d = 0; d < 8; d++)
      digit(d, (d == 5) ? 8'h49 : (d == 7) ? 8'h00 : seg_tab[d], 7);
    dwell(8'h00, 8'h00, 3);
    check("bad_seg_err",   48'(last_err), 48'h20);
    check("bad_seg_nib5",  48'(last_bcd[23:20]), 48'hE);
    check("blank_nib7",    48'(last_bcd[31:28]), 48'hF);

    // Partial frame discarded by reset
    for (int d = 0; d < 5; d++) digit(d, seg_tab[d], 6);
    do_reset("mid_reset");

    // Scan loss: partial frame, long gap, then resume
    for (int d = 0; d < 4; d++) digit(d, seg_tab[1], 6);
    check("lost_before_gap", 48'(bus.scan_lost), 48'd0);
    dwell(8'h00, 8'h00, TIMEOUT + 20);
    check("lost_after_gap", 48'(bus.scan_lost), 48'd1);
    f0 = frames;
    digit(4, seg_tab[4], 8);
    check("lost_cleared", 48'(bus.scan_lost), 48'd0);
    for (int d = 5; d < 8; d++) digit(d, seg_tab[d], 8);
    check("resume_no_early_frame", 48'(frames - f0), 48'd0);
    for (int d = 0; d < 4; d++) digit(d, seg_tab[d], 8);
    dwell(8'h00, 8'h00, 3);
    check("resume_frame", 48'(frames - f0), 48'd1);
    check("resume_digits", 48'(last_bcd), 48'h76543210);

    // Randomised scan, mostly in order, with junk, short dwells and odd patterns
    p = 0;
    for (int k = 0; k < 220; k++) begin
      sel_kind = $urandom_range(0, 9);
      if (sel_kind < 2) begin
        case ($urandom_range(0, 3))
          0: junk = 8'h00;
          1: junk = 8'h03;
          2: junk = 8'hC0;
          default: junk = 8'hFF;
        endcase
        dwell(junk, 8'($urandom), $urandom_range(1, 4));
      end else begin
        case ($urandom_range(0, 19))
          0: seg = 8'h40;
          1: seg = 8'h00;
          2: seg = 8'($urandom);
          default: seg = seg_tab[$urandom_range(0, 9)];
        endcase
        if ($urandom_range(0, 3) == 0) seg[7] = 1'b1;
        if ($urandom_range(0, 9) == 0) p = $urandom_range(0, 7);
        digit(p, seg, $urandom_range(SETTLE - 2, SETTLE + 4));
        p = (p + 1) % 8;
      end
    end

    dwell(8'h00, 8'h00, 10);
    check("queue_drained", 48'(exp_q.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
